// File: rtl/ram_fifo_replay_if.sv
// Handshake bundle between the ram_fifo_replay FIFO and its producer/consumer.
// "release" is a reserved word, so the drop-mark strobe is named mark_release.
interface ram_fifo_replay_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  wr_req;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  mark;
    logic                  mark_release;
    logic                  rewind;
    logic                  wr_err;
    logic                  rd_err;

    // FIFO side
    modport slave (
        input  wr_req, wr_data, rd_req, mark, mark_release, rewind,
        output full, almost_full, rd_data, rd_valid, empty, count, wr_err, rd_err
    );

    // Producer/consumer side
    modport master (
        output wr_req, wr_data, rd_req, mark, mark_release, rewind,
        input  full, almost_full, rd_data, rd_valid, empty, count, wr_err, rd_err
    );
endinterface

// File: rtl/ram_fifo_replay.sv
// Synchronous FIFO on an inferred RAM with a 2-cycle registered read path and
// a mark/rewind replay window. While a mark is held, the marked region counts
// as occupied so the producer cannot overwrite words that may be replayed.
module ram_fifo_replay #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter string       RAM_TYPE   = "block",
    parameter int unsigned AFULL_TH   = (1 << ADDR_WIDTH) - 4
) (
    input  logic              clk,
    input  logic              reset,
    ram_fifo_replay_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AFULL_P = ptr_t'(AFULL_TH);
    localparam ptr_t ONE_P   = ptr_t'(1);

    (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    ptr_t                  mark_ptr;
    logic                  mark_valid;
    ptr_t                  base_ptr;
    ptr_t                  held;
    ptr_t                  rd_ptr_nxt;
    logic                  full_w;
    logic                  empty_w;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rewind_hit;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;
    logic                  wr_err_r;
    logic                  rd_err_r;

    // Occupancy flags and accept decisions from the registered pointers
    always_comb begin
        base_ptr   = mark_valid ? mark_ptr : rd_ptr;
        held       = wr_ptr - base_ptr;
        full_w     = (held == DEPTH_P);
        empty_w    = (wr_ptr == rd_ptr);
        wr_acc     = bus.wr_req & ~full_w;
        rd_acc     = bus.rd_req & ~empty_w & ~bus.rewind;
        rewind_hit = bus.rewind & mark_valid;
        rd_ptr_nxt = rd_ptr;
        if (rewind_hit) begin
            rd_ptr_nxt = mark_ptr;
        end else if (rd_acc) begin
            rd_ptr_nxt = rd_ptr + ONE_P;
        end
    end

    assign bus.full        = full_w;
    assign bus.almost_full = (held >= AFULL_P);
    assign bus.empty       = empty_w;
    assign bus.count       = wr_ptr - rd_ptr;
    assign bus.rd_data     = rd_data_r;
    assign bus.rd_valid    = rd_valid_r;
    assign bus.wr_err      = wr_err_r;
    assign bus.rd_err      = rd_err_r;

    // Pointer, replay-mark and sticky error state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mark_ptr   <= '0;
            mark_valid <= 1'b0;
            wr_err_r   <= 1'b0;
            rd_err_r   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (bus.wr_req & full_w) begin
                wr_err_r <= 1'b1;
            end
            if (bus.rd_req & empty_w & ~bus.rewind) begin
                rd_err_r <= 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            // A rewind consumes the existing mark, so a simultaneous mark keeps it
            if (bus.mark) begin
                if (!rewind_hit) begin
                    mark_ptr <= rd_ptr_nxt;
                end
                mark_valid <= 1'b1;
            end else if (bus.mark_release) begin
                mark_valid <= 1'b0;
            end
        end
    end

    // Storage array and its read register, kept reset-free for RAM inference
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
        if (rd_acc) begin
            ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    // Output register stage giving the 2-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            pipe_valid <= rd_acc;
            rd_valid_r <= pipe_valid;
            if (pipe_valid) begin
                rd_data_r <= ram_q;
            end
        end
    end
endmodule

// File: tb/tb_ram_fifo_replay.sv
// Directed bench for ram_fifo_replay (depth 4, almost_full at 3) against a
// sequence-number model of the FIFO with a due-cycle schedule for read data.
module tb_ram_fifo_replay;
    logic clk = 1'b0;
    logic reset = 1'b0;
    bit   started = 1'b0;
    int   total = 0;
    int   bad = 0;

    ram_fifo_replay_if #(.DATA_WIDTH(10), .ADDR_WIDTH(2)) bus ();

    ram_fifo_replay #(
        .DATA_WIDTH(10),
        .ADDR_WIDTH(2),
        .RAM_TYPE("block"),
        .AFULL_TH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: absolute word sequence numbers, read data due two cycles after accept
    int         m_wr = 0;
    int         m_rd = 0;
    int         m_mk = 0;
    bit         m_mv = 1'b0;
    bit         m_wrerr = 1'b0;
    bit         m_rderr = 1'b0;
    int         cyc = 0;
    logic [9:0] store [64];
    bit         due_v [8];
    logic [9:0] due_d [8];
    logic [9:0] m_last = '0;
    int         m_held;
    int         m_cnt;
    bit         m_full;
    bit         m_af;
    bit         m_empty;
    bit         wa;
    bit         ra;
    bit         rw;

    always_comb begin
        m_held  = m_wr - (m_mv ? m_mk : m_rd);
        m_cnt   = m_wr - m_rd;
        m_full  = (m_held == 4);
        m_af    = (m_held >= 3);
        m_empty = (m_cnt == 0);
        wa      = bus.wr_req && !m_full;
        ra      = bus.rd_req && !m_empty && !bus.rewind;
        rw      = bus.rewind && m_mv;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wr    <= 0;
            m_rd    <= 0;
            m_mk    <= 0;
            m_mv    <= 1'b0;
            m_wrerr <= 1'b0;
            m_rderr <= 1'b0;
            m_last  <= '0;
            for (int i = 0; i < 8; i++) due_v[i] <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (wa) begin
                store[m_wr % 64] <= bus.wr_data;
                m_wr <= m_wr + 1;
            end
            if (bus.wr_req && m_full) m_wrerr <= 1'b1;
            if (bus.rd_req && m_empty && !bus.rewind) m_rderr <= 1'b1;
            if (rw) m_rd <= m_mk;
            else if (ra) m_rd <= m_rd + 1;
            if (bus.mark) begin
                if (!rw) m_mk <= m_rd + (ra ? 1 : 0);
                m_mv <= 1'b1;
            end else if (bus.mark_release) begin
                m_mv <= 1'b0;
            end
            due_v[cyc % 8] <= 1'b0;
            if (ra) begin
                due_v[(cyc + 2) % 8] <= 1'b1;
                due_d[(cyc + 2) % 8] <= store[m_rd % 64];
            end
            if (due_v[(cyc + 1) % 8]) m_last <= due_d[(cyc + 1) % 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (started && !reset) begin
            chk("full", 32'(bus.full), 32'(m_full));
            chk("almost_full", 32'(bus.almost_full), 32'(m_af));
            chk("empty", 32'(bus.empty), 32'(m_empty));
            chk("count", 32'(bus.count), 32'(m_cnt));
            chk("rd_valid", 32'(bus.rd_valid), 32'(due_v[cyc % 8]));
            chk("rd_data", 32'(bus.rd_data), 32'(m_last));
            chk("wr_err", 32'(bus.wr_err), 32'(m_wrerr));
            chk("rd_err", 32'(bus.rd_err), 32'(m_rderr));
        end
    end

    task automatic step(input bit w, input logic [9:0] d, input bit r,
                        input bit mk, input bit rl, input bit rwd);
        bus.wr_req       = w;
        bus.wr_data      = d;
        bus.rd_req       = r;
        bus.mark         = mk;
        bus.mark_release = rl;
        bus.rewind       = rwd;
        @(negedge clk);
        bus.wr_req       = 1'b0;
        bus.rd_req       = 1'b0;
        bus.mark         = 1'b0;
        bus.mark_release = 1'b0;
        bus.rewind       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [9:0] d);
        step(1, d, 0, 0, 0, 0);
    endtask

    task automatic rd();
        step(0, '0, 1, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.wr_req = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
        bus.mark = 1'b0; bus.mark_release = 1'b0; bus.rewind = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        started = 1'b1;
        chk("reset empty", 32'(bus.empty), 1);
        chk("reset count", 32'(bus.count), 0);
        chk("reset full", 32'(bus.full), 0);
        chk("reset rd_data", 32'(bus.rd_data), 0);

        // Fill to full, overflow, drain in order
        wr(10'h001); wr(10'h002); wr(10'h003);
        chk("af at 3", 32'(bus.almost_full), 1);
        chk("not full at 3", 32'(bus.full), 0);
        wr(10'h004);
        chk("full at 4", 32'(bus.full), 1);
        wr(10'h3FF);
        chk("wr_err overflow", 32'(bus.wr_err), 1);
        chk("count after overflow", 32'(bus.count), 4);
        for (int i = 0; i < 6; i++) begin
            step(0, '0, (i < 4), 0, 0, 0);
            if (i >= 1 && i <= 4) begin
                chk("drain valid", 32'(bus.rd_valid), 1);
                chk("drain data", 32'(bus.rd_data), i);
            end
        end
        chk("drained empty", 32'(bus.empty), 1);
        chk("drained valid low", 32'(bus.rd_valid), 0);

        // Read and write together on an empty FIFO
        step(1, 10'h055, 1, 0, 0, 0);
        chk("rd_err on empty", 32'(bus.rd_err), 1);
        chk("count 1", 32'(bus.count), 1);
        rd(); idle(1);
        chk("rd 55 valid", 32'(bus.rd_valid), 1);
        chk("rd 55 data", 32'(bus.rd_data), 32'h055);

        // Read and write together on a full FIFO
        wr(10'h001); wr(10'h002); wr(10'h003); wr(10'h004);
        step(1, 10'h005, 1, 0, 0, 0);
        chk("full rw count", 32'(bus.count), 3);
        idle(1);
        chk("full rw data", 32'(bus.rd_data), 1);
        rd(); rd(); rd(); idle(2);
        chk("rd 4 last", 32'(bus.rd_data), 4);

        // Mark, partial read, rewind and replay; mark holds space; wrap after release
        wr(10'h010); wr(10'h011); wr(10'h012); wr(10'h013);
        step(0, '0, 0, 1, 0, 0);
        rd(); rd(); rd();
        step(0, '0, 0, 0, 0, 1);
        chk("count after rewind", 32'(bus.count), 4);
        rd(); rd(); rd(); rd(); idle(2);
        chk("replay last", 32'(bus.rd_data), 32'h013);
        chk("marked full", 32'(bus.full), 1);
        wr(10'h03A);
        chk("marked write rejected", 32'(bus.count), 0);
        step(0, '0, 0, 0, 1, 0);
        chk("released not full", 32'(bus.full), 0);
        wr(10'h020); wr(10'h021); wr(10'h022); wr(10'h023);
        chk("wrap count", 32'(bus.count), 4);
        rd(); rd(); rd(); rd(); idle(2);
        chk("wrap last", 32'(bus.rd_data), 32'h023);

        // Asynchronous reset between edges with reads in flight
        wr(10'h030); wr(10'h031); wr(10'h032); wr(10'h033);
        step(1, 10'h034, 1, 0, 0, 0);
        chk("full rw count 2", 32'(bus.count), 3);
        step(1, 10'h035, 1, 0, 0, 0);
        wr(10'h036);
        bus.rd_req = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async empty", 32'(bus.empty), 1);
        chk("async full", 32'(bus.full), 0);
        chk("async af", 32'(bus.almost_full), 0);
        chk("async count", 32'(bus.count), 0);
        chk("async rd_valid", 32'(bus.rd_valid), 0);
        chk("async rd_data", 32'(bus.rd_data), 0);
        chk("async wr_err", 32'(bus.wr_err), 0);
        #1 reset = 1'b0;
        bus.rd_req = 1'b0;
        @(negedge clk);
        idle(1);
        chk("no valid after reset", 32'(bus.rd_valid), 0);
        idle(1);
        chk("no valid after reset 2", 32'(bus.rd_valid), 0);
        wr(10'h0AA);
        chk("count after reset write", 32'(bus.count), 1);
        rd(); idle(1);
        chk("rd AA", 32'(bus.rd_data), 32'h0AA);

        // Rewind without a mark drops the read silently
        wr(10'h041);
        step(0, '0, 1, 0, 0, 1);
        chk("unmarked rewind count", 32'(bus.count), 1);
        chk("unmarked rewind rd_err", 32'(bus.rd_err), 0);
        idle(2);
        chk("unmarked rewind no valid", 32'(bus.rd_valid), 0);
        rd(); idle(1);
        chk("rd 41", 32'(bus.rd_data), 32'h041);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_fifo_replay.md
Name: ram_fifo_replay

Overview:
Parametrised synchronous FIFO built on an inferred RAM. It replaces the free-running auto-address RAM used for activation and weight staging. It adds full/empty/occupancy tracking, a flow-controlled read path with a 2-cycle registered latency, and a mark/rewind replay window. The replay window lets the PE array re-read a stored tile without the producer re-sending it. Sits between the off-chip interface unpacker and the PE-array input registers.

Parameters:
DATA_WIDTH, 10, width of one stored word.
ADDR_WIDTH, 12, log2 of depth; DEPTH = 2^ADDR_WIDTH words (exactly DEPTH, no spare location).
RAM_TYPE, "block", synthesis RAM_STYLE attribute applied to the storage array.
AFULL_TH, DEPTH-4, almost_full asserts when held words >= AFULL_TH.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
wr_req  in  1  write request.
wr_data  in  DATA_WIDTH  write data.
full  out  1  no free location; writes are rejected.
almost_full  out  1  held words >= AFULL_TH.
rd_req  in  1  read request.
rd_data  out  DATA_WIDTH  read data, valid when rd_valid=1.
rd_valid  out  1  one-cycle pulse per accepted read.
empty  out  1  no unread word.
count  out  ADDR_WIDTH+1  unread words, equal to wr_ptr - rd_ptr.
mark  in  1  set the replay base to the current read pointer.
release  in  1  drop the replay base.
rewind  in  1  reset the read pointer to the replay base.
wr_err  out  1  sticky; set by wr_req while full.
rd_err  out  1  sticky; set by rd_req while empty.

Behaviour:
- Pointers wr_ptr, rd_ptr and mark_ptr are ADDR_WIDTH+1 bits wide. The MSB is the wrap bit. Addresses are the low ADDR_WIDTH bits, which wrap naturally at DEPTH.
- base_ptr = mark_ptr when mark_valid=1, else rd_ptr. held = wr_ptr - base_ptr.
- full = (held == DEPTH). almost_full = (held >= AFULL_TH). empty = (wr_ptr == rd_ptr). All three are combinational from registered pointers.
- Write accepted iff wr_req & !full. On accept: mem[wr_ptr] <= wr_data and wr_ptr++. wr_req & full: no effect on storage, wr_err <= 1.
- Read accepted iff rd_req & !empty & !rewind.
  - Cycle N (accept): RAM read register captures mem[rd_ptr]; rd_ptr++.
  - Cycle N+1: output register loads rd_data.
  - rd_valid is high during cycle N+2, i.e. 2-clk latency, matching the existing RAM.
  - Back-to-back accepts give back-to-back rd_valid.
  - rd_data holds its last value when no read completes.
- rd_req & empty: rd_err <= 1, nothing issued. rd_req during a rewind cycle is a silent drop, not an error.
- There is no fall-through. A word written in cycle N is readable (empty=0) from cycle N+1.
- Simultaneous read and write:
  - Both are evaluated against the flags at the start of the cycle.
  - When full, the read is accepted and the write is rejected.
  - When empty, the write is accepted and the read is rejected.
- mark:
  - mark_ptr <= rd_ptr value after this cycle's read increment; mark_valid <= 1.
  - mark while mark_valid=1 moves the base.
- release: mark_valid <= 0. Held space is freed next cycle. mark and release in the same cycle: mark wins.
- rewind:
  - If mark_valid=1: rd_ptr <= mark_ptr, and count recomputes next cycle. If mark_valid=0: rewind is ignored.
  - Reads already in the 2-stage pipe still complete with rd_valid.
  - rewind and mark in the same cycle: rd_ptr <= mark_ptr and the mark is unchanged.
- Writes may proceed during replay. full guards the marked region from overwrite.
- Asynchronous reset takes effect immediately, mid-transfer included:
  - Pointers, mark_valid, wr_err, rd_err, rd_valid, rd_data and the pipeline valid are cleared to 0.
  - Resulting outputs: empty=1, full=0, almost_full=0, count=0.
  - RAM contents are not cleared.
  - Reads in flight are discarded and do not produce rd_valid.

Test Plan:
- ADDR_WIDTH=2, AFULL_TH=3. Write 0x001..0x004 -> almost_full at count=3, full=1 at count=4. 5th write 0x3FF -> rejected, wr_err=1. Read 4 -> rd_data 0x001..0x004 on rd_valid, each 2 cycles after its accept; then empty=1.
- Empty FIFO, rd_req and wr_req=0x055 in the same cycle -> read rejected, rd_err=1, count=1. rd_req next cycle -> 0x055 with rd_valid 2 cycles later.
- Full FIFO holding 1..4, rd_req and wr_req=0x005 in the same cycle -> 0x001 read, write rejected, count=3.
- Write 0x010..0x013, mark, read 3 words, rewind -> count=4. Read 4 -> 0x010..0x013. While the mark is held, a write with count=0 is still rejected as full. After release, writes 0x020..0x023 are accepted across the pointer wrap.
- Write 6 words with pointer wrap and reads in flight, then pulse reset asynchronously between clock edges -> all outputs 0 (empty=1) immediately, no rd_valid follows. Write 0x0AA -> count=1, read returns 0x0AA.
- rewind with mark_valid=0 while rd_req=1 -> rd_ptr unchanged, read dropped, rd_err stays 0.
